// File: rtl/loop_controller_pkg.sv
// Shared types for the fetch-side loop controller: PC/opcode types, loop opcodes
// and the controller state encoding.
package loop_controller_pkg;

  typedef logic [15:0] PROGRAM_COUNTER;
  typedef logic [3:0]  op_code;

  localparam op_code OP_LOOP_OPEN  = 4'h7;
  localparam op_code OP_LOOP_CLOSE = 4'h8;

  typedef enum logic [1:0] {RUN, SKIP, FAULT} loop_state_t;

endpackage

// File: rtl/loop_stack.sv
// LIFO of loop-start PCs with combinational top; push when full and pop when
// empty are ignored so the controller owns all structural error handling.
module loop_stack
  import loop_controller_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  PROGRAM_COUNTER             data_i,
  output PROGRAM_COUNTER             top_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  PROGRAM_COUNTER   mem_q [DEPTH];
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] top_cnt;
  logic             push_ok, pop_ok;

  assign full_o  = (depth_q == CNT_W'(DEPTH));
  assign empty_o = (depth_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign top_cnt = depth_q - CNT_W'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_cnt[IDX_W-1:0]];
  assign depth_o = depth_q;

  always_comb begin
    depth_d = depth_q;
    if (push_ok)     depth_d = depth_q + CNT_W'(1);
    else if (pop_ok) depth_d = depth_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Storage needs no reset: entries at or above depth are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[depth_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/loop_controller.sv
// Loop-open/close sequencer for the fetch PC mux: backward jumps via a return
// stack, forward skip-scan on a zero cell, and a sticky structural fault.
//
//   state | meaning
//   RUN   | normal execution; OPEN pushes, CLOSE jumps back or pops
//   SKIP  | scanning forward to the matching CLOSE, datapath suppressed
//   FAULT | overflow/underflow/runaway scan; PC frozen until reset
module loop_controller
  import loop_controller_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NEST_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  PROGRAM_COUNTER             pc,
  input  op_code                     instruction,
  input  logic                       cell_zero,
  output logic                       pc_src,
  output PROGRAM_COUNTER             pc_loaded,
  output logic                       skip,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       fault
);

  loop_state_t       state_q, state_d;
  logic [NEST_W-1:0] nest_q, nest_d;
  logic              push, pop, full, empty;
  PROGRAM_COUNTER    top;

  loop_stack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc),
    .top_o   (top),
    .depth_o (depth),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d   = state_q;
    nest_d    = nest_q;
    push      = 1'b0;
    pop       = 1'b0;
    pc_src    = 1'b0;
    pc_loaded = '0;
    skip      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (instruction == OP_LOOP_OPEN) begin
          if (cell_zero) begin
            nest_d  = NEST_W'(1);
            state_d = SKIP;
          end else if (full) begin
            state_d = FAULT;
          end else begin
            push = 1'b1;
          end
        end else if (instruction == OP_LOOP_CLOSE) begin
          if (empty) begin
            state_d = FAULT;
          end else if (!cell_zero) begin
            pc_src    = 1'b1;
            pc_loaded = top + 16'd1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      SKIP: begin
        skip = 1'b1;
        if (instruction == OP_LOOP_OPEN) begin
          if (&nest_q) state_d = FAULT;
          else         nest_d  = nest_q + NEST_W'(1);
        end else if (instruction == OP_LOOP_CLOSE) begin
          if (nest_q == NEST_W'(1)) begin
            nest_d  = '0;
            state_d = RUN;
          end else begin
            nest_d = nest_q - NEST_W'(1);
          end
        end
        // A matching CLOSE at the last address still counts as found.
        if (pc == 16'hFFFF && state_d == SKIP) state_d = FAULT;
      end
      FAULT: begin
        skip      = 1'b1;
        pc_src    = 1'b1;
        pc_loaded = pc;
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      nest_q  <= '0;
    end else begin
      state_q <= state_d;
      nest_q  <= nest_d;
    end
  end

  assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_loop_controller.sv
// Scoreboard bench for loop_controller: a queue/counter reference model predicts
// each cycle's outputs, a negedge monitor compares them.
module tb_loop_controller;
  import loop_controller_pkg::*;

  localparam op_code OP_NOP = 4'h0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  PROGRAM_COUNTER pc = '0;
  op_code         instruction = OP_NOP;
  logic           cell_zero = 1'b0;
  logic           pc_src;
  PROGRAM_COUNTER pc_loaded;
  logic           skip;
  logic [4:0]     depth;
  logic           fault;

  int checks = 0;
  int failures = 0;

  loop_controller #(.DEPTH(16), .NEST_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .cell_zero   (cell_zero),
    .pc_src      (pc_src),
    .pc_loaded   (pc_loaded),
    .skip        (skip),
    .depth       (depth),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_src;
    logic [15:0] pc_loaded;
    logic        skip;
    logic [4:0]  depth;
    logic        fault;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  // Reference model: loop starts as a PC list, scan depth as a plain integer.
  logic [15:0] m_stack[$];
  bit          m_scan;
  bit          m_fault;
  int          m_nest;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".pc_src"},    32'(pc_src),    32'(e.pc_src));
      chk({t, ".pc_loaded"}, 32'(pc_loaded), 32'(e.pc_loaded));
      chk({t, ".skip"},      32'(skip),      32'(e.skip));
      chk({t, ".depth"},     32'(depth),     32'(e.depth));
      chk({t, ".fault"},     32'(fault),     32'(e.fault));
    end
  end

  task automatic model_clear();
    m_stack.delete();
    m_scan  = 0;
    m_fault = 0;
    m_nest  = 0;
  endtask

  task automatic step(input logic [15:0] p, input op_code op, input logic cz, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    pc = p;
    instruction = op;
    cell_zero = cz;
    e = '0;
    e.depth = 5'(m_stack.size());
    e.fault = m_fault;
    if (m_fault) begin
      e.pc_src = 1'b1;
      e.pc_loaded = p;
      e.skip = 1'b1;
    end else if (m_scan) begin
      e.skip = 1'b1;
      if (op == OP_LOOP_OPEN) begin
        if (m_nest == 255) m_fault = 1;
        else m_nest++;
      end else if (op == OP_LOOP_CLOSE) begin
        m_nest--;
        if (m_nest == 0) m_scan = 0;
      end
      if (m_scan && p == 16'hFFFF) m_fault = 1;
    end else begin
      if (op == OP_LOOP_OPEN) begin
        if (cz) begin
          m_scan = 1;
          m_nest = 1;
        end else if (m_stack.size() == 16) m_fault = 1;
        else m_stack.push_back(p);
      end else if (op == OP_LOOP_CLOSE) begin
        if (m_stack.size() == 0) m_fault = 1;
        else if (!cz) begin
          e.pc_src = 1'b1;
          e.pc_loaded = m_stack[m_stack.size()-1] + 16'd1;
        end else void'(m_stack.pop_back());
      end
    end
    if (m_fault) m_scan = 0;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Reset lands mid-cycle; outputs must clear without any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    instruction = OP_NOP;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_pc_src"}, 32'(pc_src), 32'd0);
    chk({tag, ".rst_skip"},   32'(skip),   32'd0);
    chk({tag, ".rst_fault"},  32'(fault),  32'd0);
    chk({tag, ".rst_depth"},  32'(depth),  32'd0);
    model_clear();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int faulted_cycles;
    logic [15:0] pcv;
    model_clear();
    #3;
    chk("por.pc_src", 32'(pc_src), 32'd0);
    chk("por.fault",  32'(fault),  32'd0);
    chk("por.depth",  32'(depth),  32'd0);
    do_reset("init");

    step(16'h0010, OP_LOOP_OPEN,  1'b0, "bj_open");
    step(16'h0014, OP_LOOP_CLOSE, 1'b0, "bj_close_jump");
    step(16'h0014, OP_LOOP_CLOSE, 1'b1, "bj_close_exit");
    step(16'h0015, OP_NOP,        1'b0, "bj_after");

    step(16'h0020, OP_LOOP_OPEN,  1'b1, "ns_open0");
    step(16'h0021, OP_NOP,        1'b0, "ns_other");
    step(16'h0022, OP_LOOP_OPEN,  1'b0, "ns_open1");
    step(16'h0023, OP_LOOP_CLOSE, 1'b0, "ns_close1");
    step(16'h0024, OP_LOOP_CLOSE, 1'b1, "ns_close0");
    step(16'h0025, OP_NOP,        1'b0, "ns_resume");

    for (int i = 0; i < 17; i++) step(16'h0100 + 16'(i), OP_LOOP_OPEN, 1'b0, "ovf_open");
    for (int i = 0; i < 5; i++) step(16'h0111, OP_NOP, 1'b0, "ovf_hold");
    do_reset("ovf");

    step(16'h0030, OP_LOOP_CLOSE, 1'b0, "udf_close");
    for (int i = 0; i < 4; i++) step(16'h0031 + 16'(i), OP_NOP, 1'b0, "udf_hold");
    do_reset("udf");

    step(16'h0038, OP_LOOP_OPEN, 1'b1, "rs_open0");
    step(16'h0039, OP_LOOP_OPEN, 1'b0, "rs_open1");
    step(16'h003A, OP_LOOP_OPEN, 1'b1, "rs_open2");
    step(16'h003B, OP_NOP,       1'b0, "rs_nest3");
    do_reset("rs_mid_skip");
    step(16'h0040, OP_LOOP_OPEN, 1'b0, "rs_push");
    step(16'h0041, OP_NOP,       1'b0, "rs_depth1");
    do_reset("rs");

    step(16'h0200, OP_LOOP_OPEN, 1'b1, "nest_enter");
    for (int i = 1; i < 256; i++) step(16'h0200 + 16'(i), OP_LOOP_OPEN, 1'b0, "nest_climb");
    step(16'h0300, OP_NOP, 1'b0, "nest_fault");
    do_reset("nest");

    step(16'hFFFE, OP_LOOP_OPEN, 1'b1, "end_enter");
    step(16'hFFFF, OP_NOP,       1'b0, "end_runaway");
    step(16'hFFFF, OP_NOP,       1'b0, "end_fault");
    do_reset("end");

    pcv = 16'h0400;
    faulted_cycles = 0;
    for (int n = 0; n < 2000; n++) begin
      int r;
      op_code op;
      r = int'($urandom_range(0, 9));
      if (r < 3)      op = OP_LOOP_OPEN;
      else if (r < 6) op = OP_LOOP_CLOSE;
      else            op = op_code'($urandom_range(9, 15));
      step(pcv, op, 1'($urandom_range(0, 1)), "rnd");
      pcv = (pcv >= 16'h7FF0) ? 16'h0400 : pcv + 16'(1 + $urandom_range(0, 2));
      faulted_cycles = m_fault ? faulted_cycles + 1 : 0;
      if (faulted_cycles > 3) begin
        do_reset("rnd");
        faulted_cycles = 0;
      end
    end

    repeat (2) @(posedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
